// File: rtl/vc_index_stream_decoder.sv
// rtl/vc_index_stream_decoder.sv - rebuilds a bit vector from a stream of encoded bit indices
module vc_index_stream_decoder #(
  parameter int NBITS     = 32,
  parameter int IDX_NBITS = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_val,
  output logic                 in_rdy,
  input  logic [IDX_NBITS+1:0] in_bits,
  output logic                 out_val,
  input  logic                 out_rdy,
  output logic [NBITS-1:0]     out_bits,
  output logic                 out_err,
  output logic [IDX_NBITS:0]   out_cnt
);

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_EMIT  = 1'b1
  } state_t;

  localparam logic [IDX_NBITS:0] NBITS_LIM = (IDX_NBITS+1)'(NBITS);
  localparam logic [IDX_NBITS:0] CNT_MAX   = '1;
  localparam logic [NBITS-1:0]   ONE       = {{(NBITS-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [NBITS-1:0]     acc_q, acc_d;
  logic                 err_q, err_d;
  logic [IDX_NBITS:0]   cnt_q, cnt_d;

  logic                 beat_last;
  logic                 beat_idx_val;
  logic [IDX_NBITS-1:0] beat_idx;
  logic                 in_range;
  logic [NBITS-1:0]     one_hot;

  assign beat_last    = in_bits[IDX_NBITS+1];
  assign beat_idx_val = in_bits[IDX_NBITS];
  assign beat_idx     = in_bits[IDX_NBITS-1:0];

  // Decode the beat's index; the one-hot is only produced for a valid index so a
  // don't-care index on an idx_val=0 beat never reaches the accumulator.
  always_comb begin
    in_range = 1'b0;
    one_hot  = '0;
    if (beat_idx_val) begin
      in_range = ({1'b0, beat_idx} < NBITS_LIM);
      if (in_range) begin
        one_hot = ONE << beat_idx;
      end
    end
  end

  // Next-state: merge beats while accumulating, hold and then clear around the emit handshake.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ACCUM: begin
        if (in_val) begin
          if (beat_idx_val) begin
            if (in_range) begin
              acc_d = acc_q | one_hot;
              if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 1'b1;
              end
            end else begin
              err_d = 1'b1;
            end
          end
          if (beat_last) begin
            state_d = ST_EMIT;
          end
        end
      end
      ST_EMIT: begin
        if (out_rdy) begin
          acc_d   = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_ACCUM;
        end
      end
      default: begin
        state_d = ST_ACCUM;
      end
    endcase
  end

  // State and accumulator registers; reset discards any partial or pending vector.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_ACCUM;
      acc_q   <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_rdy   = (state_q == ST_ACCUM);
  assign out_val  = (state_q == ST_EMIT);
  assign out_bits = acc_q;
  assign out_err  = err_q;
  assign out_cnt  = cnt_q;

endmodule

// File: tb/tb_vc_index_stream_decoder.sv
// tb/tb_vc_index_stream_decoder.sv - randomized self-checking bench for vc_index_stream_decoder
module tb_vc_index_stream_decoder;

  logic        clk;
  logic        reset;
  logic        in_val;
  logic [6:0]  in_bits;
  logic        out_rdy;

  logic        in_rdy_a,  out_val_a,  out_err_a;
  logic [31:0] out_bits_a;
  logic [5:0]  out_cnt_a;
  logic        in_rdy_b,  out_val_b,  out_err_b;
  logic [23:0] out_bits_b;
  logic [5:0]  out_cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [6:0] beats[$];

  vc_index_stream_decoder #(.NBITS(32), .IDX_NBITS(5)) dut_a (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy_a), .in_bits(in_bits),
    .out_val(out_val_a), .out_rdy(out_rdy), .out_bits(out_bits_a),
    .out_err(out_err_a), .out_cnt(out_cnt_a)
  );

  vc_index_stream_decoder #(.NBITS(24), .IDX_NBITS(5)) dut_b (
    .clk(clk), .reset(reset), .in_val(in_val), .in_rdy(in_rdy_b), .in_bits(in_bits),
    .out_val(out_val_b), .out_rdy(out_rdy), .out_bits(out_bits_b),
    .out_err(out_err_b), .out_cnt(out_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_beat(input bit last, input bit vld, input int idx);
    logic [4:0] i5;
    i5 = idx[4:0];
    beats.push_back({last, vld, i5});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Sends the queued beats (last one closes the vector), then checks the emitted
  // vector against a reference built from the indices, stalls, and consumes it.
  task automatic run_vector(input int stall, input bit gaps);
    logic [31:0] e32;
    logic [23:0] e24;
    int          c32, c24;
    bit          r24;
    logic [6:0]  b;
    int          idx;
    e32 = '0; e24 = '0; c32 = 0; c24 = 0; r24 = 0;
    for (int i = 0; i < beats.size(); i++) begin
      b = beats[i];
      if (gaps && $urandom_range(0, 3) == 0) begin
        in_val  = 1'b0;
        in_bits = 7'($urandom);
        tick();
      end
      check_eq("in_rdy_accum", {31'b0, in_rdy_a}, 32'd1);
      in_val  = 1'b1;
      in_bits = b;
      tick();
      in_val  = 1'b0;
      in_bits = 7'($urandom);
      if (b[5]) begin
        idx = int'(b[4:0]);
        e32 = e32 | (32'd1 << idx);
        c32 = (c32 < 63) ? c32 + 1 : 63;
        if (idx < 24) begin
          e24 = e24 | (24'd1 << idx);
          c24 = (c24 < 63) ? c24 + 1 : 63;
        end else begin
          r24 = 1;
        end
      end
      if (!b[6]) begin
        check_eq("partial_val", {31'b0, out_val_a}, 32'd0);
        check_eq("partial_bits", out_bits_a, e32);
      end
    end
    beats.delete();
    out_rdy = 1'b0;
    for (int s = 0; s <= stall; s++) begin
      check_eq("emit_val",    {31'b0, out_val_a}, 32'd1);
      check_eq("emit_rdy",    {31'b0, in_rdy_a},  32'd0);
      check_eq("emit_bits",   out_bits_a, e32);
      check_eq("emit_cnt",    {26'b0, out_cnt_a}, 32'(c32));
      check_eq("emit_err",    {31'b0, out_err_a}, 32'd0);
      check_eq("emit24_val",  {31'b0, out_val_b}, 32'd1);
      check_eq("emit24_bits", {8'b0, out_bits_b}, {8'b0, e24});
      check_eq("emit24_cnt",  {26'b0, out_cnt_b}, 32'(c24));
      check_eq("emit24_err",  {31'b0, out_err_b}, {31'b0, r24});
      in_val  = 1'($urandom);
      in_bits = 7'($urandom);
      if (s == stall) out_rdy = 1'b1;
      tick();
    end
    out_rdy = 1'b0;
    in_val  = 1'b0;
    check_eq("after_val",  {31'b0, out_val_a}, 32'd0);
    check_eq("after_rdy",  {31'b0, in_rdy_a},  32'd1);
    check_eq("after_bits", out_bits_a, 32'd0);
    check_eq("after_cnt",  {26'b0, out_cnt_a}, 32'd0);
    check_eq("after24_err", {31'b0, out_err_b}, 32'd0);
  endtask

  initial begin
    reset = 1'b0; in_val = 1'b0; in_bits = '0; out_rdy = 1'b0;
    #2;
    check_eq("rst_async_rdy", {31'b0, in_rdy_a}, 32'd1);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();
    check_eq("rst_in_rdy",   {31'b0, in_rdy_a},  32'd1);
    check_eq("rst_out_val",  {31'b0, out_val_a}, 32'd0);
    check_eq("rst_out_bits", out_bits_a, 32'd0);
    check_eq("rst_out_cnt",  {26'b0, out_cnt_a}, 32'd0);

    push_beat(1, 1, 31);
    run_vector(0, 0);

    push_beat(0, 1, 31); push_beat(0, 1, 30); push_beat(0, 1, 29); push_beat(1, 1, 28);
    run_vector(1, 0);
    push_beat(0, 1, 24); push_beat(1, 1, 0);
    run_vector(0, 0);

    push_beat(1, 0, 13);
    run_vector(0, 0);

    push_beat(0, 1, 20); push_beat(0, 1, 20); push_beat(1, 1, 12);
    run_vector(5, 0);

    for (int i = 0; i < 32; i++) push_beat(i == 31, 1, i);
    run_vector(0, 0);
    push_beat(1, 1, 4);
    run_vector(0, 0);

    for (int i = 0; i < 70; i++) push_beat(i == 69, 1, i % 32);
    run_vector(1, 0);

    push_beat(0, 1, 30); push_beat(0, 0, 27); push_beat(1, 1, 3);
    run_vector(0, 0);

    in_val = 1'b1; in_bits = {1'b0, 1'b1, 5'd31}; tick();
    in_bits = {1'b0, 1'b1, 5'd20}; tick();
    in_val = 1'b0;
    #2 reset = 1'b0;
    #1;
    check_eq("midrst_bits", out_bits_a, 32'd0);
    check_eq("midrst_val",  {31'b0, out_val_a}, 32'd0);
    check_eq("midrst_cnt",  {26'b0, out_cnt_a}, 32'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    tick();
    check_eq("postrst_val", {31'b0, out_val_a}, 32'd0);
    push_beat(1, 1, 12);
    run_vector(0, 0);

    push_beat(1, 1, 7);
    run_vector(1, 0);
    @(posedge clk);
    #1 reset = 1'b0;
    #1;
    check_eq("emitrst_val", {31'b0, out_val_a}, 32'd0);
    check_eq("emitrst_rdy", {31'b0, in_rdy_a},  32'd1);
    #2 reset = 1'b1;
    tick();

    for (int v = 0; v < 30; v++) begin
      int len;
      len = $urandom_range(1, 8);
      for (int i = 0; i < len; i++) begin
        push_beat(i == len - 1, $urandom_range(0, 3) != 0, $urandom_range(0, 31));
      end
      run_vector($urandom_range(0, 3), 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
